// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART defaults, frame constants and TX state type
package uart_pkg;

  // Board defaults, shared with the receive path
  localparam int CLK_FREQ_DEFAULT = 50_000_000;
  localparam int BAUDRATE_DEFAULT = 9_600;

  // 8N1 frame shape
  localparam int   DATA_BITS   = 8;
  localparam int   STOP_BITS   = 1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic IDLE_LEVEL  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - restartable modulo-DIV counter with terminal-count tick
module uart_baud_counter #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic tick
);

  localparam int              CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   TERM = CW'(DIV - 1);

  logic [CW-1:0] r_count;

  assign tick = enable && (r_count == TERM);

  // Restart lets bit edges line up with byte acceptance instead of a free-running tick
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= tick ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with valid/ready byte input
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEFAULT,
  parameter int BAUDRATE = BAUDRATE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       TxD,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int DIV = CLK_FREQ / BAUDRATE;

  tx_state_t            r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [2:0]           r_bit_cnt;
  logic                 r_txd;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_handshake;
  logic                 w_tick;

  assign w_handshake = tx_valid && r_ready;

  assign TxD      = r_txd;
  assign tx_ready = r_ready;
  assign tx_busy  = r_busy;
  assign tx_done  = r_done;

  uart_baud_counter #(
    .DIV (DIV)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .restart (w_handshake),
    .enable  (r_busy),
    .tick    (w_tick)
  );

  // TxD lags the state by one clock so the line never glitches on a state change
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_txd     <= IDLE_LEVEL;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_txd <= IDLE_LEVEL;
          if (w_handshake) begin
            r_shift   <= tx_data;
            r_bit_cnt <= '0;
            r_state   <= ST_START;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        ST_START: begin
          r_txd <= START_LEVEL;
          if (w_tick) begin
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          r_txd <= r_shift[0];
          if (w_tick) begin
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
              r_state <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          r_txd <= IDLE_LEVEL;
          if (w_tick) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx
module tb_uart_tx;

  localparam int DIV_S = 10;
  localparam int DIV_D = 5208;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] tx_data_s, tx_data_d;
  logic       tx_valid_s, tx_valid_d;
  logic       tx_ready_s, TxD_s, tx_busy_s, tx_done_s;
  logic       tx_ready_d, TxD_d, tx_busy_d, tx_done_d;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int n_done_d = 0;
  logic [7:0] exp_s[$];
  logic [7:0] exp_d[$];
  int start_t[$];
  int done_t[$];

  uart_tx #(.CLK_FREQ(1000), .BAUDRATE(100)) dut_s (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data_s),
    .tx_valid (tx_valid_s),
    .tx_ready (tx_ready_s),
    .TxD      (TxD_s),
    .tx_busy  (tx_busy_s),
    .tx_done  (tx_done_s)
  );

  uart_tx dut_d (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data_d),
    .tx_valid (tx_valid_d),
    .tx_ready (tx_ready_d),
    .TxD      (TxD_d),
    .tx_busy  (tx_busy_d),
    .tx_done  (tx_done_d)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done_s === 1'b1) done_t.push_back(cyc);
    if (tx_done_d === 1'b1) n_done_d++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic line_of(input int sel);
    return (sel == 0) ? TxD_s : TxD_d;
  endfunction

  function automatic logic done_of(input int sel);
    return (sel == 0) ? tx_done_s : tx_done_d;
  endfunction

  // Monitor: frames the line from its first low sample, checks widths, mid-bit decodes, pops expectation
  task automatic watch(input int sel);
    int         div;
    int         bad_w;
    int         done_bad;
    int         qsz;
    bit         aborted;
    logic [9:0] first_v;
    logic [9:0] mid_v;
    logic [7:0] got;
    logic [7:0] exp_b;
    div = (sel == 0) ? DIV_S : DIV_D;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && line_of(sel) === 1'b0) begin
        if (sel == 0) start_t.push_back(cyc);
        bad_w = 0;
        done_bad = 0;
        aborted = 1'b0;
        first_v = '0;
        mid_v = '0;
        for (int i = 0; i < 10 * div; i++) begin
          if (i > 0) @(negedge clk);
          if (reset !== 1'b0) begin
            aborted = 1'b1;
            break;
          end
          if (i % div == 0) first_v[i / div] = line_of(sel);
          else if (line_of(sel) !== first_v[i / div]) bad_w++;
          if (i % div == div / 2) mid_v[i / div] = line_of(sel);
          if (done_of(sel) !== (i == 10 * div - 1)) done_bad++;
        end
        if (!aborted) begin
          got = mid_v[8:1];
          check("frame_start_bit", mid_v[0], 0);
          check("frame_stop_bit", mid_v[9], 1);
          check("frame_bit_width", bad_w, 0);
          check("frame_done_align", done_bad, 0);
          qsz = (sel == 0) ? exp_s.size() : exp_d.size();
          check("frame_expected", qsz != 0, 1);
          if (qsz != 0) begin
            if (sel == 0) exp_b = exp_s.pop_front();
            else exp_b = exp_d.pop_front();
            check("frame_byte", got, exp_b);
          end
        end
      end
    end
  endtask

  initial watch(0);
  initial watch(1);

  // Called at a negedge; returns hs = index of the accepting edge
  task automatic send_s(input logic [7:0] d, input bit expect_frame, output int hs);
    int n;
    tx_data_s = d;
    tx_valid_s = 1'b1;
    n = 0;
    while (tx_ready_s !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) check("send_ready_timeout", n, 0);
    if (expect_frame) exp_s.push_back(d);
    @(negedge clk);
    hs = cyc;
    tx_valid_s = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int hs, hs1, hs2, n0, d0, bad, lows;
    reset = 1'b1;
    tx_data_s = 8'h00;
    tx_valid_s = 1'b0;
    tx_data_d = 8'h00;
    tx_valid_d = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 1: reset state and quiet idle
    check("rst_txd", TxD_s, 1);
    check("rst_ready", tx_ready_s, 1);
    check("rst_busy", tx_busy_s, 0);
    check("rst_done", tx_done_s, 0);
    check("rst_def_txd", TxD_d, 1);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (TxD_s !== 1'b1 || tx_busy_s !== 1'b0 || tx_ready_s !== 1'b1 || tx_done_s !== 1'b0) bad++;
    end
    check("idle_quiet", bad, 0);

    // 2: 0x55 timing
    n0 = start_t.size();
    d0 = done_t.size();
    send_s(8'h55, 1'b1, hs);
    check("t2_busy", tx_busy_s, 1);
    repeat (10 * DIV_S + 10) @(negedge clk);
    check("t2_frames", start_t.size() - n0, 1);
    check("t2_dones", done_t.size() - d0, 1);
    if (start_t.size() > n0) check("t2_start_edge", start_t[n0] - hs, 1);
    if (done_t.size() > d0) check("t2_done_edge", done_t[d0] - hs, 10 * DIV_S);

    // 3: back-to-back 0x00, 0xFF with valid held
    n0 = start_t.size();
    d0 = done_t.size();
    send_s(8'h00, 1'b1, hs1);
    send_s(8'hFF, 1'b1, hs2);
    check("t3_accept_gap", hs2 - hs1, 10 * DIV_S + 1);
    repeat (10 * DIV_S + 10) @(negedge clk);
    check("t3_frames", start_t.size() - n0, 2);
    check("t3_dones", done_t.size() - d0, 2);
    if (start_t.size() > n0 + 1) check("t3_second_start", start_t[n0 + 1] - hs1, 10 * DIV_S + 2);
    if (done_t.size() > d0 + 1) check("t3_done_gap", done_t[d0 + 1] - done_t[d0], 10 * DIV_S + 1);

    // 4: mid-frame data change and valid pulse are ignored
    n0 = start_t.size();
    tx_data_s = 8'h00;
    send_s(8'hA5, 1'b1, hs);
    lows = 0;
    for (int i = 0; i < 120; i++) begin
      if (i == 30) begin
        tx_data_s = 8'h3C;
        tx_valid_s = 1'b1;
      end
      if (i == 31) tx_valid_s = 1'b0;
      if (tx_ready_s === 1'b0) lows++;
      @(negedge clk);
    end
    check("t4_ready_low_cycles", lows, 10 * DIV_S);
    repeat (50) @(negedge clk);
    check("t4_single_frame", start_t.size() - n0, 1);

    // 5: reset mid-frame aborts, next byte framed correctly
    d0 = done_t.size();
    send_s(8'hC3, 1'b0, hs);
    repeat (45 - (cyc - hs)) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_abort_edge", cyc - hs, 46);
    check("t5_txd", TxD_s, 1);
    check("t5_ready", tx_ready_s, 1);
    check("t5_busy", tx_busy_s, 0);
    repeat (20) @(negedge clk);
    check("t5_no_done", done_t.size() - d0, 0);
    n0 = start_t.size();
    send_s(8'h81, 1'b1, hs);
    repeat (10 * DIV_S + 10) @(negedge clk);
    check("t5_new_frames", start_t.size() - n0, 1);
    check("t5_new_done", done_t.size() - d0, 1);

    // 6: default divider, 0x4B
    tx_data_d = 8'h4B;
    tx_valid_d = 1'b1;
    exp_d.push_back(8'h4B);
    @(negedge clk);
    tx_valid_d = 1'b0;
    check("t6_busy", tx_busy_d, 1);
    repeat (10 * DIV_D + 20) @(negedge clk);
    check("t6_done_count", n_done_d, 1);
    check("t6_queue_empty", exp_d.size(), 0);

    check("all_s_frames_seen", exp_s.size(), 0);
    check("total_done_s", done_t.size(), 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: accepts one byte per valid/ready handshake and drives 8N1 frames on `TxD`. The frame is one start bit (0), eight data bits LSB first, and one stop bit (1). It is the transmit-side counterpart of the UART receive path and feeds the board-level serial line. Its baud timing is derived from the 50 MHz system clock by an integer divider, with no oversampling.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUDRATE`, default 9_600: line rate in bit/s.
- `DIV` (derived, local), CLK_FREQ/BAUDRATE (integer truncation, 5208 at defaults): clocks per bit; must be ≥ 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `tx_data`  in  8  byte to send; sampled only on handshake.
- `tx_valid`  in  1  upstream has a byte.
- `tx_ready`  out  1  block can accept a byte; handshake = `tx_valid && tx_ready` at a rising edge.
- `TxD`  out  1  serial line, idles high.
- `tx_busy`  out  1  high while a frame is on the line (START..STOP).
- `tx_done`  out  1  one-cycle pulse after stop bit completes.

## Operation
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx_ready`=1, `TxD`=1. On handshake: latch `tx_data` into an 8-bit shift register, clear the baud counter and bit counter, and go to START.
  - START: `TxD`=0 for DIV clocks, then go to DATA.
  - DATA: `TxD`=shift[0]. Every DIV clocks, shift right and increment the bit counter (3 bits). After bit 7 has been held DIV clocks, go to STOP.
  - STOP: `TxD`=1 for DIV clocks, then go to IDLE with `tx_done`=1 for that first IDLE cycle.
- Baud counter: width `$clog2(DIV)`. It counts 0..DIV-1 only while not in IDLE, with its terminal count at DIV-1. It is restarted on every handshake, so bit edges align to acceptance rather than to a free-running tick.
- `TxD` is a registered output (glitch-free), driven directly from the state and the shift register.
- `tx_busy` = state ≠ IDLE. `tx_ready` = state == IDLE.
- `tx_data` and `tx_valid` are ignored outside IDLE; changing `tx_data` mid-frame has no effect.
- Reset values: state=IDLE, `TxD`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0, counters=0.
- Reset mid-frame aborts the frame: `TxD`=1 at the next edge, no `tx_done` pulse, and the partial byte is discarded.
- Simultaneous `tx_done` and a new handshake in the same cycle is legal. The next start bit begins the following cycle.

## Timing
- Handshake at edge 0 puts `TxD` low from edge 1. The start bit occupies edges 1..DIV.
- Data bit k occupies edges (k+1)·DIV+1 .. (k+2)·DIV. The stop bit occupies edges 9·DIV+1 .. 10·DIV.
- `tx_done` and `tx_ready` are high in the cycle after edge 10·DIV.
- Frame period with `tx_valid` held continuously is 10·DIV+1 clocks. There is one extra idle-high clock between frames, which is within receiver stop-bit tolerance.
- Bit-time error from integer truncation is ≤ 1 clock per bit (< 0.02 % at defaults).

## Structure
- Shared package `uart_pkg` holds:
  - the CLK_FREQ and BAUDRATE defaults, shared with the receiver;
  - the frame constants: 8 data bits, 1 stop bit, start level 0, idle level 1;
  - the TX state enum.
- Sub-module `uart_baud_counter` is natural: a restartable modulo-DIV counter with a `restart` input and a `tick` output at terminal count. The receiver can later reuse it with a ×4 divisor.

## Test plan
Use CLK_FREQ=1000 and BAUDRATE=100 (DIV=10) for speed.
1. Reset asserted 3 cycles, then released → `TxD`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0; no activity with `tx_valid`=0 for 200 cycles.
2. Send 0x55 at edge 0 → `TxD` low edges 1–10; then bits 1,0,1,0,1,0,1,0 each 10 clocks; high edges 91–100; `tx_done` pulse at cycle 101 only.
3. Send 0x00 then 0xFF back-to-back with `tx_valid` held → second start bit begins edge 102. Line reads 0,00000000,1 then 0,11111111,1; two `tx_done` pulses, 101 cycles apart.
4. Start 0xA5, then at edge 30 change `tx_data` to 0x3C and pulse `tx_valid` → `tx_ready`=0 throughout the frame; serialized byte remains 0xA5; no second frame.
5. Start 0xC3, assert `reset` at edge 45 for 1 cycle → `TxD`=1 from edge 46; `tx_ready`=1, `tx_busy`=0; no `tx_done`. A new 0x81 sent afterwards is framed correctly.
6. Default parameters, send 0x4B → each bit lasts exactly 5208 clocks; a bench model sampling at mid-bit decodes 0x4B with a valid stop bit.
